seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Eight-digit multiplexed seven-segment driver for the board's numeric display.
- Sits directly downstream of the IO manager's display-value mux: it consumes the selected 32-bit debug word and drives the digit-select and segment pins (num_an, num_csn).
- Double-buffers the word so a digit never shows a mix of old and new data (frame-atomic update).
- Scans at a programmable rate and adds anti-ghosting blanking and optional leading-zero suppression.

Parameters:
- SCAN_DIV, 12500: clk cycles per digit slot; 100 MHz gives an 8 kHz digit rate and a 1 kHz frame rate. Legal range 2..65535.
- BLANK_CYC, 64: cycles at the start of each digit slot with all digits off (anti-ghost). Legal range 0..SCAN_DIV-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- value  in  32  hex word to display; nibble i goes to digit i, digit 0 is rightmost
- dots  in  8  decimal point per digit; bit i drives digit i
- blank_lz  in  1  suppress leading zero digits
- load  in  1  single-cycle strobe that captures value, dots and blank_lz into the shadow register
- num_an  out  8  digit select, active low, bit i selects digit i
- num_csn  out  8  segments, active low, order {dp,g,f,e,d,c,b,a}
- frame_start  out  1  one-cycle pulse when digit 0 slot begins
- pending  out  1  high while the shadow register holds data not yet shown

Behaviour:
- Reset (rst high at a clk edge) sets:
  - prescaler = 0, digit index = 0
  - shadow and display registers = 0
  - pending = 0, frame_start = 0
  - num_an = 8'hFF, num_csn = 8'hFF (display dark)
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. tick = (prescaler == SCAN_DIV-1).
- Digit index: 3 bits; on tick it increments modulo 8 (7 -> 0).
- Load:
  - When load is high, shadow <= {value, dots, blank_lz} and pending <= 1 on the same edge.
  - A load while pending is already 1 overwrites the shadow; the last load wins and no stall occurs.
- Frame commit:
  - Condition: tick with index == 7.
  - If pending is 1, the display register <= shadow and pending <= 0.
  - If load and commit fall in the same cycle, the new load data goes to the shadow only, pending stays 1, and the display register takes the old shadow contents.
- frame_start: registered; high for exactly the one cycle after the 7 -> 0 wrap.
- Outputs: registered, one cycle after the state they reflect.
  - If prescaler < BLANK_CYC: num_an = 8'hFF (blank slot).
  - Otherwise, if digit[index] is leading-zero blanked: num_an = 8'hFF.
  - Otherwise: num_an = ~(8'b1 << index), num_csn = ~{dp[index], hex7(nibble[index])}.
  - num_csn is don't-care while num_an = 8'hFF; the RTL drives 8'hFF there.
- Leading-zero blanking: digit i (i = 1..7) is blanked when the display blank_lz = 1 and display nibbles i..7 are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- A dot on a blanked digit is not shown.
- Hex font (1 = segment on, {g..a}):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Reset mid-scan: on the next edge the display goes dark, the scan restarts at digit 0, and any pending data is discarded.
- BLANK_CYC = 0: no blanking slot; the digit is on for the whole slot.

Decomposition:
- Package seg7_pkg holds:
  - SEG_FONT[16] localparam array (7-bit codes, above)
  - DIGITS = 8
  - a typedef disp_word_t: struct of {value[31:0], dots[7:0], blank_lz}
- Sub-module seg7_hex_decoder: purely combinational nibble -> 7-bit active-high segments, indexed from SEG_FONT.
- The scan, buffering and blanking logic stays in seg7_scan_driver.

Test Plan (SCAN_DIV=4, BLANK_CYC=1 unless noted):
- Reset held 3 cycles, then released with no load -> num_an stays 8'hFF during blank cycles; digit 0 shows num_csn=8'hC0; digits 1..7 show 8'hC0 while blank_lz=0; first frame_start occurs 32 cycles after release.
- load value=32'h89ABCDEF, dots=0, blank_lz=0 mid-frame -> pending=1 until the 7->0 wrap; digits 0..7 then show num_csn 8E,86,A1,C6,83,88,90,80; pending=0.
- value=32'h00000A05, blank_lz=1 -> digits 0,1,2 lit (92, C0, 88); digits 3..7 have num_an=8'hFF in their slots.
- Two loads (32'h1111_1111, then 32'h2222_2222) before one commit -> the next frame shows all digits 8'hA4; 32'h1111_1111 is never displayed.
- load asserted on the exact commit cycle with pending=1 (prior shadow=32'h1, new=32'h2) -> that frame shows 1 on digit 0, the next frame shows 2; pending falls only after the second commit.
- dots=8'h01, value=0, blank_lz=1 -> digit 0 shows num_csn=8'h40. With dots=8'h02 instead, no dp appears because digit 1 is blanked.
- rst asserted mid-frame -> num_an=8'hFF next edge, index restarts at 0, pending=0, display=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and font table for the seven-segment scan driver
package seg7_pkg;

  localparam int DIGITS = 8;

  // Active-high segment codes {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One complete frame's worth of display data
  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dots;
    logic        blank_lz;
  } disp_word_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - data-in and display-out bundle of the scan driver
interface seg7_scan_driver_if;

  logic [31:0] value;
  logic [7:0]  dots;
  logic        blank_lz;
  logic        load;
  logic [7:0]  num_an;
  logic [7:0]  num_csn;
  logic        frame_start;
  logic        pending;

  // Producer of display words / consumer of pin state
  modport master (
    output value, dots, blank_lz, load,
    input  num_an, num_csn, frame_start, pending
  );

  // The scan driver itself
  modport slave (
    input  value, dots, blank_lz, load,
    output num_an, num_csn, frame_start, pending
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - nibble to active-high seven-segment code
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight lookup into the shared font table
  always_comb begin
    seg = SEG_FONT[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - eight-digit multiplexed display scanner with frame-atomic update
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 12500,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_driver_if.slave bus
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYC);

  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  disp_word_t  shadow_q, shadow_d;
  disp_word_t  disp_q, disp_d;
  logic        pending_q, pending_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  num_an_q, num_an_d;
  logic [7:0]  num_csn_q, num_csn_d;

  logic        tick;
  logic        frame_end;
  logic        commit;
  logic        blank_slot;
  logic [7:0]  lz_blank;
  logic [3:0]  cur_nibble;
  logic [6:0]  cur_seg;
  logic        cur_dp;
  logic        lit;

  assign tick      = (presc_q == PRESC_MAX);
  assign frame_end = tick && (idx_q == 3'd7);
  assign commit    = frame_end && pending_q;

  // Anti-ghost window at the head of every digit slot; absent entirely when BLANK_CYC is 0
  if (BLANK_CYC == 0) begin : g_no_blank
    assign blank_slot = 1'b0;
  end else begin : g_blank
    assign blank_slot = (presc_q < BLANK_LIM);
  end

  // Leading-zero mask: digit i is dark when every nibble from i up to 7 is zero
  always_comb begin
    logic zero_run;
    lz_blank = '0;
    zero_run = disp_q.blank_lz;
    for (int i = 7; i >= 1; i--) begin
      zero_run    = zero_run & (disp_q.value[i*4 +: 4] == 4'h0);
      lz_blank[i] = zero_run;
    end
  end

  assign cur_nibble = disp_q.value[{idx_q, 2'b00} +: 4];
  assign cur_dp     = disp_q.dots[idx_q];
  assign lit        = !blank_slot && !lz_blank[idx_q];

  seg7_hex_decoder u_hex (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Next-state for scan counters, double buffer and registered pin drive
  always_comb begin
    presc_d       = tick ? 16'd0 : presc_q + 16'd1;
    idx_d         = tick ? idx_q + 3'd1 : idx_q;
    // Last load wins; a load coinciding with commit stays in the shadow for the next frame
    shadow_d      = bus.load ? '{value: bus.value, dots: bus.dots, blank_lz: bus.blank_lz}
                             : shadow_q;
    disp_d        = commit ? shadow_q : disp_q;
    pending_d     = bus.load | (pending_q & ~commit);
    frame_start_d = frame_end;
    num_an_d      = 8'hFF;
    num_csn_d     = 8'hFF;
    if (lit) begin
      num_an_d  = ~(8'b1 << idx_q);
      num_csn_d = ~{cur_dp, cur_seg};
    end
  end

  // State update with synchronous reset to a dark display at digit 0
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      disp_q        <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      num_an_q      <= 8'hFF;
      num_csn_q     <= 8'hFF;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      disp_q        <= disp_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      num_an_q      <= num_an_d;
      num_csn_q     <= num_csn_d;
    end
  end

  assign bus.num_an      = num_an_q;
  assign bus.num_csn     = num_csn_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap_an [8];
  logic [7:0] cap_csn [8];
  logic [7:0] cap_blank_an [8];

  function automatic logic [7:0] an_sel(input int d);
    logic [7:0] one;
    one = 8'h01;
    return 8'hFF ^ (one << d);
  endfunction

  // Wait (bounded) for frame_start; returns cycle count or -1 on timeout
  task automatic wait_frame(output int cycles);
    bit found;
    found  = 0;
    cycles = -1;
    for (int k = 1; k <= 80; k++) begin
      if (!found) begin
        @(negedge clk);
        if (bus.frame_start === 1'b1) begin
          found  = 1;
          cycles = k;
        end
      end
    end
  endtask

  // Called on the frame_start cycle; records the blank and lit sample of every slot
  task automatic capture_frame();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k % 4 == 0) cap_blank_an[k/4] = bus.num_an;
      if (k % 4 == 1) begin
        cap_an[k/4]  = bus.num_an;
        cap_csn[k/4] = bus.num_csn;
      end
    end
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic lz);
    bus.value    = v;
    bus.dots     = d;
    bus.blank_lz = lz;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.num_an !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h expected ff", bus.num_an); end
    n_checks++; if (bus.num_csn !== 8'hFF) begin n_fail++; $display("FAIL reset_csn: got %h expected ff", bus.num_csn); end
    n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", bus.pending); end
    n_checks++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", bus.frame_start); end
    rst = 1'b0;
    wait_frame(n);
    n_checks++; if (n != 32) begin n_fail++; $display("FAIL first_frame_latency: got %0d expected 32", n); end
    capture_frame();
    for (int d = 0; d < 8; d++) begin
      n_checks++; if (cap_blank_an[d] !== 8'hFF) begin n_fail++; $display("FAIL reset_blank_slot%0d: got %h expected ff", d, cap_blank_an[d]); end
      n_checks++; if (cap_an[d] !== an_sel(d)) begin n_fail++; $display("FAIL reset_an%0d: got %h expected %h", d, cap_an[d], an_sel(d)); end
      n_checks++; if (cap_csn[d] !== 8'hC0) begin n_fail++; $display("FAIL reset_csn%0d: got %h expected c0", d, cap_csn[d]); end
    end
  endtask

  task automatic test_load_pattern();
    int n;
    logic [7:0] exp_csn [8];
    exp_csn = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    repeat (10) @(negedge clk);
    do_load(32'h89ABCDEF, 8'h00, 1'b0);
    n_checks++; if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL load_pending_set: got %b expected 1", bus.pending); end
    wait_frame(n);
    n_checks++; if (n < 0) begin n_fail++; $display("FAIL load_frame_timeout: got %0d expected >0", n); end
    n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL load_pending_clear: got %b expected 0", bus.pending); end
    capture_frame();
    for (int d = 0; d < 8; d++) begin
      n_checks++; if (cap_an[d] !== an_sel(d)) begin n_fail++; $display("FAIL pattern_an%0d: got %h expected %h", d, cap_an[d], an_sel(d)); end
      n_checks++; if (cap_csn[d] !== exp_csn[d]) begin n_fail++; $display("FAIL pattern_csn%0d: got %h expected %h", d, cap_csn[d], exp_csn[d]); end
    end
  endtask

  task automatic test_leading_zero();
    int n;
    logic [7:0] exp_csn [3];
    exp_csn = '{8'h92, 8'hC0, 8'h88};
    do_load(32'h00000A05, 8'h00, 1'b1);
    wait_frame(n);
    n_checks++; if (n < 0) begin n_fail++; $display("FAIL lz_frame_timeout: got %0d expected >0", n); end
    capture_frame();
    for (int d = 0; d < 3; d++) begin
      n_checks++; if (cap_an[d] !== an_sel(d)) begin n_fail++; $display("FAIL lz_an%0d: got %h expected %h", d, cap_an[d], an_sel(d)); end
      n_checks++; if (cap_csn[d] !== exp_csn[d]) begin n_fail++; $display("FAIL lz_csn%0d: got %h expected %h", d, cap_csn[d], exp_csn[d]); end
    end
    for (int d = 3; d < 8; d++) begin
      n_checks++; if (cap_an[d] !== 8'hFF) begin n_fail++; $display("FAIL lz_dark_an%0d: got %h expected ff", d, cap_an[d]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_load(32'h11111111, 8'h00, 1'b0);
    do_load(32'h22222222, 8'h00, 1'b0);
    wait_frame(n);
    n_checks++; if (n < 0) begin n_fail++; $display("FAIL b2b_frame_timeout: got %0d expected >0", n); end
    capture_frame();
    for (int d = 0; d < 8; d++) begin
      n_checks++; if (cap_csn[d] !== 8'hA4) begin n_fail++; $display("FAIL b2b_csn%0d: got %h expected a4", d, cap_csn[d]); end
    end
  endtask

  // Entered on a frame_start cycle; second load lands exactly on the commit edge
  task automatic test_load_on_commit();
    do_load(32'h00000001, 8'h00, 1'b0);
    repeat (30) @(negedge clk);
    do_load(32'h00000002, 8'h00, 1'b0);
    n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL coc_align_fs: got %b expected 1", bus.frame_start); end
    n_checks++; if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL coc_pending_held: got %b expected 1", bus.pending); end
    capture_frame();
    n_checks++; if (cap_csn[0] !== 8'hF9) begin n_fail++; $display("FAIL coc_first_csn0: got %h expected f9", cap_csn[0]); end
    n_checks++; if (cap_csn[1] !== 8'hC0) begin n_fail++; $display("FAIL coc_first_csn1: got %h expected c0", cap_csn[1]); end
    n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL coc_second_fs: got %b expected 1", bus.frame_start); end
    n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL coc_pending_clear: got %b expected 0", bus.pending); end
    capture_frame();
    n_checks++; if (cap_csn[0] !== 8'hA4) begin n_fail++; $display("FAIL coc_second_csn0: got %h expected a4", cap_csn[0]); end
  endtask

  task automatic test_dots();
    int n;
    do_load(32'h0, 8'h01, 1'b1);
    wait_frame(n);
    n_checks++; if (n < 0) begin n_fail++; $display("FAIL dots_frame_timeout: got %0d expected >0", n); end
    capture_frame();
    n_checks++; if (cap_csn[0] !== 8'h40) begin n_fail++; $display("FAIL dots_dp0_csn: got %h expected 40", cap_csn[0]); end
    n_checks++; if (cap_an[1] !== 8'hFF) begin n_fail++; $display("FAIL dots_d1_dark: got %h expected ff", cap_an[1]); end
    do_load(32'h0, 8'h02, 1'b1);
    wait_frame(n);
    capture_frame();
    n_checks++; if (cap_csn[0] !== 8'hC0) begin n_fail++; $display("FAIL dots_nodp0_csn: got %h expected c0", cap_csn[0]); end
    n_checks++; if (cap_an[1] !== 8'hFF) begin n_fail++; $display("FAIL dots_hidden_an1: got %h expected ff", cap_an[1]); end
    n_checks++; if (cap_csn[1] !== 8'hFF) begin n_fail++; $display("FAIL dots_hidden_csn1: got %h expected ff", cap_csn[1]); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    do_load(32'h12345678, 8'h00, 1'b0);
    wait_frame(n);
    repeat (9) @(negedge clk);
    do_load(32'hFFFFFFFF, 8'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.num_an !== 8'hFF) begin n_fail++; $display("FAIL midrst_an: got %h expected ff", bus.num_an); end
    n_checks++; if (bus.num_csn !== 8'hFF) begin n_fail++; $display("FAIL midrst_csn: got %h expected ff", bus.num_csn); end
    n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL midrst_pending: got %b expected 0", bus.pending); end
    rst = 1'b0;
    wait_frame(n);
    n_checks++; if (n != 32) begin n_fail++; $display("FAIL midrst_restart: got %0d expected 32", n); end
    n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL midrst_no_commit: got %b expected 0", bus.pending); end
    capture_frame();
    n_checks++; if (cap_csn[0] !== 8'hC0) begin n_fail++; $display("FAIL midrst_csn0: got %h expected c0", cap_csn[0]); end
    n_checks++; if (cap_csn[7] !== 8'hC0) begin n_fail++; $display("FAIL midrst_csn7: got %h expected c0", cap_csn[7]); end
  endtask

  initial begin
    rst          = 1'b1;
    bus.value    = '0;
    bus.dots     = '0;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b0;
    test_reset();
    test_load_pattern();
    test_leading_zero();
    test_back_to_back();
    test_load_on_commit();
    test_dots();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
